// File: rtl/classify_pkg.sv
// Shared types and constants for the classify_master run controller.
package classify_pkg;

  localparam int DATA_W = 32;
  localparam int NPTS_W = 16;

  localparam logic [2:0] ADDR_NPTS   = 3'd0;
  localparam logic [2:0] ADDR_STREAM = 3'd1;
  localparam logic [2:0] ADDR_I_PT   = 3'd2;
  localparam logic [2:0] ADDR_Q_PT   = 3'd3;
  localparam logic [2:0] ADDR_I_VEC  = 3'd4;
  localparam logic [2:0] ADDR_Q_VEC  = 3'd5;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [NPTS_W-1:0]        npts;
    logic                     stream;
    logic signed [DATA_W-1:0] i_pt;
    logic signed [DATA_W-1:0] q_pt;
    logic signed [DATA_W-1:0] i_vec;
    logic signed [DATA_W-1:0] q_vec;
  } cfg_regs_t;

endpackage

// File: rtl/classify_cfg_regs.sv
// Shadow configuration register file; writable at any time, sampled by the sequencer in ARM.
module classify_cfg_regs
  import classify_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output cfg_regs_t         shadow,
  output logic              bad_addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        ADDR_NPTS:   shadow.npts   <= cfg_data[NPTS_W-1:0];
        ADDR_STREAM: shadow.stream <= cfg_data[0];
        ADDR_I_PT:   shadow.i_pt   <= cfg_data;
        ADDR_Q_PT:   shadow.q_pt   <= cfg_data;
        ADDR_I_VEC:  shadow.i_vec  <= cfg_data;
        ADDR_Q_VEC:  shadow.q_vec  <= cfg_data;
        default:     ;
      endcase
    end
  end

  // Same-cycle flag so the sequencer can set err on the write edge itself
  assign bad_addr = cfg_wr && (cfg_addr > ADDR_Q_VEC);

endmodule

// File: rtl/classify_sequencer.sv
// Run controller for classify_master: gates samples into the classifier for a fixed
// shot count, waits for the classifier result and latches it (batch or stream mode).
module classify_sequencer
  import classify_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                     clk100,
  input  logic                     rst_n,
  input  logic                     cfg_wr,
  input  logic [2:0]               cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     smp_valid,
  input  logic signed [DATA_W-1:0] smp_i,
  input  logic signed [DATA_W-1:0] smp_q,
  output logic                     cls_data_in,
  output logic signed [DATA_W-1:0] cls_i_val,
  output logic signed [DATA_W-1:0] cls_q_val,
  output logic [NPTS_W-1:0]        cls_num_data_pts,
  output logic                     cls_stream_mode,
  output logic signed [DATA_W-1:0] cls_i_pt_line,
  output logic signed [DATA_W-1:0] cls_q_pt_line,
  output logic signed [DATA_W-1:0] cls_i_vec_perp,
  output logic signed [DATA_W-1:0] cls_q_vec_perp,
  input  logic                     cls_result_valid,
  input  logic [127:0]             cls_result,
  output logic                     busy,
  output logic                     done,
  output logic [127:0]             result,
  output logic [NPTS_W-1:0]        shot_cnt,
  output logic                     err
);

  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  state_t            state;
  cfg_regs_t         shadow;
  cfg_regs_t         active;
  logic              bad_addr;
  logic [TMR_W-1:0]  drain_tmr;
  logic              last_shot;

  classify_cfg_regs u_cfg_regs (
    .clk      (clk100),
    .rst_n    (rst_n),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .shadow   (shadow),
    .bad_addr (bad_addr)
  );

  assign cls_num_data_pts = active.npts;
  assign cls_stream_mode  = active.stream;
  assign cls_i_pt_line    = active.i_pt;
  assign cls_q_pt_line    = active.q_pt;
  assign cls_i_vec_perp   = active.i_vec;
  assign cls_q_vec_perp   = active.q_vec;

  assign last_shot = smp_valid && ((shot_cnt + NPTS_W'(1)) == active.npts);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      active      <= '0;
      shot_cnt    <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      cls_data_in <= 1'b0;
      cls_i_val   <= '0;
      cls_q_val   <= '0;
      drain_tmr   <= '0;
    end else begin
      cls_data_in <= 1'b0;
      done        <= 1'b0;
      if (bad_addr)
        err <= 1'b1;

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (shadow.npts == '0) begin
                err <= 1'b1;
              end else begin
                state <= ARM;
                busy  <= 1'b1;
              end
            end
          end
          ARM: begin
            active   <= shadow;
            shot_cnt <= '0;
            err      <= bad_addr;
            state    <= RUN;
          end
          RUN: begin
            if (smp_valid) begin
              cls_data_in <= 1'b1;
              cls_i_val   <= smp_i;
              cls_q_val   <= smp_q;
              if (shot_cnt != active.npts)
                shot_cnt <= shot_cnt + NPTS_W'(1);
              if (last_shot) begin
                state     <= DRAIN;
                drain_tmr <= '0;
              end
            end
          end
          DRAIN: begin
            if (cls_result_valid) begin
              result <= cls_result;
              done   <= 1'b1;
              if (!active.stream) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (shadow.npts == '0) begin
                // Re-arming with zero points would never finish; stop the stream instead
                err   <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ARM;
              end
            end else if (drain_tmr == TMR_W'(DRAIN_TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              drain_tmr <= drain_tmr + TMR_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_classify_sequencer.sv
// Scoreboard bench for classify_sequencer: stimulus queues expected strobes/results,
// a negedge monitor pops and compares them, including the cycle they must appear in.
module tb_classify_sequencer;
  import classify_pkg::*;

  logic                     clk100 = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_wr = 1'b0;
  logic [2:0]               cfg_addr = '0;
  logic [DATA_W-1:0]        cfg_data = '0;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic                     smp_valid = 1'b0;
  logic signed [DATA_W-1:0] smp_i = '0;
  logic signed [DATA_W-1:0] smp_q = '0;
  logic                     cls_data_in;
  logic signed [DATA_W-1:0] cls_i_val;
  logic signed [DATA_W-1:0] cls_q_val;
  logic [NPTS_W-1:0]        cls_num_data_pts;
  logic                     cls_stream_mode;
  logic signed [DATA_W-1:0] cls_i_pt_line;
  logic signed [DATA_W-1:0] cls_q_pt_line;
  logic signed [DATA_W-1:0] cls_i_vec_perp;
  logic signed [DATA_W-1:0] cls_q_vec_perp;
  logic                     cls_result_valid = 1'b0;
  logic [127:0]             cls_result = '0;
  logic                     busy;
  logic                     done;
  logic [127:0]             result;
  logic [NPTS_W-1:0]        shot_cnt;
  logic                     err;

  classify_sequencer #(.DRAIN_TIMEOUT(64)) dut (
    .clk100           (clk100),
    .rst_n            (rst_n),
    .cfg_wr           (cfg_wr),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .start            (start),
    .abort            (abort),
    .smp_valid        (smp_valid),
    .smp_i            (smp_i),
    .smp_q            (smp_q),
    .cls_data_in      (cls_data_in),
    .cls_i_val        (cls_i_val),
    .cls_q_val        (cls_q_val),
    .cls_num_data_pts (cls_num_data_pts),
    .cls_stream_mode  (cls_stream_mode),
    .cls_i_pt_line    (cls_i_pt_line),
    .cls_q_pt_line    (cls_q_pt_line),
    .cls_i_vec_perp   (cls_i_vec_perp),
    .cls_q_vec_perp   (cls_q_vec_perp),
    .cls_result_valid (cls_result_valid),
    .cls_result       (cls_result),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .shot_cnt         (shot_cnt),
    .err              (err)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  typedef struct {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
    int                       at;
  } smp_exp_t;

  typedef struct {
    logic [127:0] v;
    int           at;
  } res_exp_t;

  smp_exp_t exp_smp[$];
  res_exp_t exp_res[$];
  smp_exp_t mon_s;
  res_exp_t mon_r;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every strobe/done must match the oldest expectation, in the stamped cycle
  always @(negedge clk100) begin
    if (rst_n) begin
      if (cls_data_in) begin
        if (exp_smp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got i=%0d q=%0d, expected no strobe", cls_i_val, cls_q_val);
        end else begin
          mon_s = exp_smp.pop_front();
          check("strobe_i", cls_i_val, mon_s.i);
          check("strobe_q", cls_q_val, mon_s.q);
          check("strobe_cycle", cyc, mon_s.at);
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got result=%0h, expected no done", result);
        end else begin
          mon_r = exp_res.pop_front();
          check("done_result", result, mon_r.v);
          check("done_cycle", cyc, mon_r.at);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [DATA_W-1:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk100);
    cfg_wr = 1'b0;
  endtask

  task automatic send(input int vi, input int vq, input bit fwd);
    smp_exp_t e;
    smp_valid = 1'b1; smp_i = vi; smp_q = vq;
    if (fwd) begin
      e.i = vi; e.q = vq; e.at = cyc + 1;
      exp_smp.push_back(e);
    end
    @(negedge clk100);
    smp_valid = 1'b0;
  endtask

  task automatic result_pulse(input logic [127:0] v, input bit expect_done);
    res_exp_t e;
    cls_result_valid = 1'b1; cls_result = v;
    if (expect_done) begin
      e.v = v; e.at = cyc + 1;
      exp_res.push_back(e);
    end
    @(negedge clk100);
    cls_result_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk100);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk100);
    abort = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [127:0] rv;
  logic [127:0] last_res;
  int           n;

  initial begin
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_shot_cnt", shot_cnt, 0);
    check("rst_err", err, 0);
    check("rst_npts", cls_num_data_pts, 0);
    check("rst_data_in", cls_data_in, 0);
    rst_n = 1'b1;
    tick(1);

    // Test 1: batch of 10, line (0,0), perp (1,1)
    cfg_write(ADDR_NPTS, 10);
    cfg_write(ADDR_STREAM, 0);
    cfg_write(ADDR_I_PT, 0);
    cfg_write(ADDR_Q_PT, 0);
    cfg_write(ADDR_I_VEC, 1);
    cfg_write(ADDR_Q_VEC, 1);
    check("t1_npts_before_arm", cls_num_data_pts, 0);
    pulse_start();
    tick(1);
    check("t1_busy", busy, 1);
    check("t1_npts_active", cls_num_data_pts, 10);
    check("t1_i_vec", cls_i_vec_perp, 1);
    check("t1_q_vec", cls_q_vec_perp, 1);
    check("t1_shot_start", shot_cnt, 0);
    for (int k = -3; k <= 6; k++) send(k, k, 1'b1);
    check("t1_shot_full", shot_cnt, 10);
    check("t1_busy_drain", busy, 1);
    rv = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    result_pulse(rv, 1'b1);
    check("t1_idle", busy, 0);
    check("t1_result", result, rv);

    // Test 2: stream mode, 3 batches of 4
    cfg_write(ADDR_NPTS, 4);
    cfg_write(ADDR_STREAM, 1);
    pulse_start();
    tick(1);
    check("t2_stream_mode", cls_stream_mode, 1);
    for (int b = 0; b < 3; b++) begin
      check("t2_shot_reset", shot_cnt, 0);
      for (int k = 0; k < 4; k++) send(b * 16 + k, -(b * 16 + k), 1'b1);
      check("t2_shot_full", shot_cnt, 4);
      rv = {32'hc0ffee00, 96'(b + 1)};
      result_pulse(rv, 1'b1);
      check("t2_busy_held", busy, 1);
      tick(1);
    end
    pulse_abort();
    check("t2_abort_idle", busy, 0);
    check("t2_last_result", result, rv);

    // Test 3: line config written mid-run only takes effect at the next ARM
    cfg_write(ADDR_STREAM, 0);
    cfg_write(ADDR_NPTS, 2);
    pulse_start();
    tick(1);
    cfg_write(ADDR_I_PT, 5);
    check("t3_i_pt_in_run", cls_i_pt_line, 0);
    send(100, 200, 1'b1);
    send(-100, -200, 1'b1);
    rv = 128'h3333_0000_0000_0000_0000_0000_0000_0005;
    result_pulse(rv, 1'b1);
    last_res = rv;
    check("t3_i_pt_after_run", cls_i_pt_line, 0);
    pulse_start();
    check("t3_i_pt_in_arm", cls_i_pt_line, 0);
    tick(1);
    check("t3_i_pt_applied", cls_i_pt_line, 5);
    pulse_abort();

    // Test 4: abort after 3 of 10 samples
    cfg_write(ADDR_NPTS, 10);
    pulse_start();
    tick(1);
    for (int k = 0; k < 3; k++) send(k + 40, k + 50, 1'b1);
    pulse_abort();
    check("t4_abort_idle", busy, 0);
    check("t4_shot_kept", shot_cnt, 3);
    for (int k = 0; k < 3; k++) send(k + 60, k + 70, 1'b0);
    result_pulse(128'hbad, 1'b0);
    check("t4_result_kept", result, last_res);
    check("t4_still_idle", busy, 0);

    // Test 5: error paths
    cfg_write(ADDR_NPTS, 0);
    pulse_start();
    check("t5_npts0_busy", busy, 0);
    check("t5_npts0_err", err, 1);
    cfg_write(ADDR_NPTS, 2);
    pulse_start();
    tick(1);
    check("t5_err_cleared", err, 0);
    pulse_abort();
    cfg_write(3'd7, 32'h1);
    check("t5_bad_addr_err", err, 1);
    pulse_start();
    tick(1);
    check("t5_err_cleared2", err, 0);
    send(1, 1, 1'b1);
    send(2, 2, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    check("t5_timeout_cycles", n, 64);
    check("t5_timeout_err", err, 1);
    check("t5_result_kept", result, last_res);

    // Test 6: async reset mid-run, then start+abort together
    cfg_write(ADDR_NPTS, 10);
    pulse_start();
    tick(1);
    send(9, 9, 1'b1);
    send(8, 8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data_in", cls_data_in, 0);
    check("t6_rst_shot", shot_cnt, 0);
    check("t6_rst_npts", cls_num_data_pts, 0);
    check("t6_rst_i_pt", cls_i_pt_line, 0);
    check("t6_rst_result", result, 0);
    check("t6_rst_err", err, 0);
    @(negedge clk100);
    rst_n = 1'b1;
    tick(1);
    cfg_write(ADDR_NPTS, 5);
    start = 1'b1; abort = 1'b1;
    @(negedge clk100);
    start = 1'b0; abort = 1'b0;
    check("t6_start_abort_busy", busy, 0);
    tick(1);
    check("t6_start_abort_busy2", busy, 0);
    check("t6_start_abort_err", err, 0);
    send(7, 7, 1'b0);

    tick(3);
    check("end_strobe_queue_empty", exp_smp.size(), 0);
    check("end_result_queue_empty", exp_res.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
